seg_scan_mux: RTL and testbench

Time-multiplexed seven-segment display driver for the UART board top level. It replaces the per-digit static decoders with one shared segment bus and one active-low anode line per digit. Write data, received data and configuration digits all reach a common-anode display through it. It registers a tear-free snapshot of the digit values once per frame and inserts a one-cycle blanking guard between digits to suppress ghosting.

---
 rtl/seg_scan_mux.sv | 146 ++++++++++++++
 tb/tb_seg_scan_mux.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_mux.sv
// seg_scan_mux: time-multiplexed common-anode seven-segment driver with a per-frame
// input snapshot and a blank guard cycle per digit. Optional DP blink: SEG_DP_BLINK_EN.
module seg_scan_mux #(
   parameter int DIGITS       = 6,
   parameter int DIV          = 50000,
   parameter int BLINK_FRAMES = 64
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [4*DIGITS-1:0]   i_nibbles,
   input  logic [DIGITS-1:0]     i_digit_en,
   input  logic [DIGITS-1:0]     i_dp,
   input  logic                  i_hold,
   output logic [6:0]            o_seg,
   output logic                  o_dp,
   output logic [DIGITS-1:0]     o_an,
   output logic                  o_frame_start
);

   localparam int CW = $clog2(DIV);
   localparam int IW = $clog2(DIGITS);
   localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
   localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);

   logic [CW-1:0]       cnt;
   logic [IW-1:0]       idx;
   logic [4*DIGITS-1:0] snap_nib;
   logic [DIGITS-1:0]   snap_en;
   logic [DIGITS-1:0]   snap_dp;
   logic                guard;
   logic                frame_start_c;
   logic                blink_phase;
   logic [3:0]          cur_nib;
   logic [6:0]          seg_c;
   logic                dp_c;
   logic [DIGITS-1:0]   an_c;

   function automatic logic [6:0] decode_hex(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0:    s = 7'b1000000;
         4'h1:    s = 7'b1111001;
         4'h2:    s = 7'b0100100;
         4'h3:    s = 7'b0110000;
         4'h4:    s = 7'b0011001;
         4'h5:    s = 7'b0010010;
         4'h6:    s = 7'b0000010;
         4'h7:    s = 7'b1111000;
         4'h8:    s = 7'b0000000;
         4'h9:    s = 7'b0010000;
         4'hA:    s = 7'b0001000;
         4'hB:    s = 7'b0000011;
         4'hC:    s = 7'b1000110;
         4'hD:    s = 7'b0100001;
         4'hE:    s = 7'b0000110;
         4'hF:    s = 7'b0001110;
         default: s = 7'h7F;
      endcase
      return s;
   endfunction

   assign guard         = (cnt == '0);
   assign frame_start_c = guard && (idx == '0);
   assign cur_nib       = snap_nib[idx*4 +: 4];

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         cnt <= '0;
         idx <= '0;
      end else if (cnt == CNT_MAX) begin
         cnt <= '0;
         idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // Captured only on the digit-0 guard edge so a frame never mixes old and new values.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         snap_nib <= '0;
         snap_en  <= '0;
         snap_dp  <= '0;
      end else if (frame_start_c && !i_hold) begin
         snap_nib <= i_nibbles;
         snap_en  <= i_digit_en;
         snap_dp  <= i_dp;
      end
   end

`ifdef SEG_DP_BLINK_EN
   localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [FW-1:0] FRM_MAX = FW'(BLINK_FRAMES - 1);

   logic [FW-1:0] frm_cnt;
   logic          frame_end;

   // Counting on the last drive cycle lets the new phase apply from the next frame's guard.
   assign frame_end = (cnt == CNT_MAX) && (idx == IDX_MAX);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         frm_cnt     <= '0;
         blink_phase <= 1'b0;
      end else if (frame_end) begin
         if (frm_cnt == FRM_MAX) begin
            frm_cnt     <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            frm_cnt <= frm_cnt + 1'b1;
         end
      end
   end
`else
   // Steady DP; the parameter stays on the interface so both builds share one instantiation.
   assign blink_phase = (BLINK_FRAMES < 0);
`endif

   always_comb begin
      seg_c = 7'h7F;
      dp_c  = 1'b1;
      an_c  = '1;
      if (!guard) begin
         an_c = ~(DIGITS'(1) << idx);
         if (snap_en[idx]) begin
            seg_c = decode_hex(cur_nib);
            dp_c  = ~(snap_dp[idx] & ~blink_phase);
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_seg         <= 7'h7F;
         o_dp          <= 1'b1;
         o_an          <= '1;
         o_frame_start <= 1'b0;
      end else begin
         o_seg         <= seg_c;
         o_dp          <= dp_c;
         o_an          <= an_c;
         o_frame_start <= frame_start_c;
      end
   end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux: per-cycle expected outputs for whole frames are
// queued from hand-decoded segment tables and compared on the falling edge.
module tb_seg_scan_mux;

   localparam int DIGITS       = 6;
   localparam int DIV          = 4;
   localparam int BLINK_FRAMES = 2;
   localparam int W            = 15;   // {frame_start, dp, seg[6:0], an[5:0]}

   // Segment patterns packed {d5,d4,d3,d2,d1,d0}
   localparam logic [41:0] SEG_A = {7'b0001110, 7'b0000110, 7'b0100001,
                                    7'b1000110, 7'b0000000, 7'b1111001};  // 24'hFEDC81
   localparam logic [41:0] SEG_B = {7'b1111000, 7'b0000010, 7'b0010010,
                                    7'b0011001, 7'b0110000, 7'b0100100};  // 24'h765432
   localparam logic [41:0] SEG_C = {7'b1000000, 7'b0010000, 7'b0001000,
                                    7'b0000110, 7'b0010010, 7'b0000011};  // 24'h09AE5B

   logic                  clk;
   logic                  rst;
   logic [4*DIGITS-1:0]   nibbles;
   logic [DIGITS-1:0]     digit_en;
   logic [DIGITS-1:0]     dp_req;
   logic                  hold;
   logic [6:0]            seg;
   logic                  dp_n;
   logic [DIGITS-1:0]     an;
   logic                  frame_start;

   logic [W-1:0] exp_q[$];
   int vec_cnt  = 0;
   int miss_cnt = 0;
   int frame_no = 0;

   seg_scan_mux #(
      .DIGITS(DIGITS),
      .DIV(DIV),
      .BLINK_FRAMES(BLINK_FRAMES)
   ) dut (
      .i_clk(clk),
      .i_rst(rst),
      .i_nibbles(nibbles),
      .i_digit_en(digit_en),
      .i_dp(dp_req),
      .i_hold(hold),
      .o_seg(seg),
      .o_dp(dp_n),
      .o_an(an),
      .o_frame_start(frame_start)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         miss_cnt++;
         $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic dp_visible(input int f);
`ifdef SEG_DP_BLINK_EN
      return ((f / BLINK_FRAMES) % 2) == 0;
`else
      return (f >= 0);
`endif
   endfunction

   task automatic check_reset_outputs(input string tag);
      check_vec({tag, "_an"},  32'(an),          32'h3F);
      check_vec({tag, "_seg"}, 32'(seg),         32'h7F);
      check_vec({tag, "_dp"},  32'(dp_n),        32'h1);
      check_vec({tag, "_fs"},  32'(frame_start), 32'h0);
   endtask

   // driver tasks
   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check_reset_outputs("rst");
      frame_no = 0;
      rst = 1'b0;
   endtask

   task automatic push_frame(input logic [41:0] segs, input logic [5:0] en, input logic [5:0] dpr);
      logic [6:0] s;
      logic       d;
      for (int k = 0; k < DIGITS; k++) begin
         exp_q.push_back({(k == 0) ? 1'b1 : 1'b0, 1'b1, 7'h7F, 6'h3F});
         s = en[k] ? segs[7*k +: 7] : 7'h7F;
         d = ~(en[k] & dpr[k] & dp_visible(frame_no));
         for (int c = 1; c < DIV; c++)
            exp_q.push_back({1'b0, d, s, ~(6'b1 << k)});
      end
      frame_no++;
   endtask

   // scoreboard
   task automatic run_check(input int n, input string tag);
      logic [W-1:0] e;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         e = exp_q.pop_front();
         check_vec({tag, "_an"},  32'(an),          32'(e[5:0]));
         check_vec({tag, "_seg"}, 32'(seg),         32'(e[12:6]));
         check_vec({tag, "_dp"},  32'(dp_n),        32'(e[13]));
         check_vec({tag, "_fs"},  32'(frame_start), 32'(e[14]));
      end
   endtask

   initial begin
      rst      = 1'b1;
      nibbles  = 24'hFEDC81;
      digit_en = 6'h3F;
      dp_req   = 6'h00;
      hold     = 1'b0;
      do_reset();

      // reset release, scan order, decode of F,E,D,C,8,1
      push_frame(SEG_A, 6'h3F, 6'h00);
      push_frame(SEG_A, 6'h3F, 6'h00);
      run_check(48, "scan");

      // digit 0 blanked, DP on digit 1
      digit_en = 6'h3E;
      dp_req   = 6'h02;
      push_frame(SEG_A, 6'h3E, 6'h02);
      run_check(24, "blank");

      // mid-frame change must wait for the next frame
      push_frame(SEG_A, 6'h3E, 6'h02);
      run_check(12, "mid");
      nibbles  = 24'h765432;
      digit_en = 6'h3F;
      dp_req   = 6'h00;
      run_check(12, "mid");
      push_frame(SEG_B, 6'h3F, 6'h00);
      run_check(24, "new");

      // hold across one frame start keeps the old snapshot
      hold    = 1'b1;
      nibbles = 24'h09AE5B;
      push_frame(SEG_B, 6'h3F, 6'h00);
      run_check(2, "hold");
      hold = 1'b0;
      run_check(22, "hold");
      push_frame(SEG_C, 6'h3F, 6'h00);
      run_check(24, "unhold");

      // asynchronous reset during digit 3 drive
      push_frame(SEG_C, 6'h3F, 6'h00);
      run_check(14, "pre_rst");
      #2 rst = 1'b1;
      #1 check_reset_outputs("async_rst");
      exp_q.delete();
      @(negedge clk);
      do_reset();
      push_frame(SEG_C, 6'h3F, 6'h00);
      run_check(24, "restart");

      // all DPs requested over several frames
      dp_req = 6'h3F;
      do_reset();
      for (int f = 0; f < 5; f++)
         push_frame(SEG_C, 6'h3F, 6'h3F);
      run_check(5 * DIGITS * DIV, "dp_all");

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule
